epf_stream_3x3: RTL and testbench

- Parametrised, streaming successor to the fixed-size edge-preserving filter top.
- Accepts one frame of IMG_W x IMG_H pixels, row-major, over a valid/ready input.
- Builds a 3x3 window internally from two line buffers.
- Emits one filtered pixel per input pixel over a valid/ready output with full backpressure, then pulses done.

---
 rtl/epf_stream_3x3.sv | 248 ++++++++++++++++++++++++
 tb/tb_epf_stream_3x3.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/epf_stream_3x3.sv
// Streaming 3x3 edge-preserving filter: valid/ready in and out, two line buffers, full backpressure.
// Optional macro EPF_BYPASS_EN adds a 'bypass' input that passes every centre pixel through unmodified.
//
// state | meaning
// IDLE  | waiting for start; thresh (and bypass) latched on start
// RUN   | accepting IMG_W*IMG_H pixels, one per advancing beat
// FLUSH | IMG_W+1 dummy beats push the final row/column through the window
// DRAIN | waiting for the m_last handshake
// DONE  | one-cycle done pulse, then back to IDLE
module epf_stream_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] thresh,
`ifdef EPF_BYPASS_EN
  input  logic              bypass,
`endif
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_pixel,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_pixel,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = $clog2(IMG_W + 2);
  localparam int SW = DATA_W + 4;
  localparam int SH = DATA_W + 8;
  localparam int QW = SH + 1;
  localparam int MW = SW + QW;
  localparam int unsigned ONE_SH = 32'd1 << SH;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN, S_DONE} state_t;
  state_t state_q, state_d;

  logic              adv, acc, beat, latch, last_pos, pre_done, flush_end, byp_on;
  logic              border_now, last_now;
  logic [CW-1:0]     in_col, out_col;
  logic [RW-1:0]     in_row, out_row;
  logic [PW-1:0]     pre_cnt, flush_cnt;
  logic [DATA_W-1:0] thr_q, beat_pix, lb0_rd, lb1_rd;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] win [9];
  logic              w_valid, w_border, w_last;

  assign adv        = !m_valid || m_ready;
  assign acc        = s_valid && s_ready;
  assign beat       = acc || (state_q == S_FLUSH && adv);
  assign last_pos   = (in_col == CW'(IMG_W - 1)) && (in_row == RW'(IMG_H - 1));
  assign pre_done   = (pre_cnt == '0);
  assign flush_end  = (state_q == S_FLUSH) && adv && (flush_cnt == '0);
  assign beat_pix   = (state_q == S_RUN) ? s_pixel : '0;
  assign lb0_rd     = lb0[in_col];
  assign lb1_rd     = lb1[in_col];
  assign border_now = (out_row == '0) || (out_row == RW'(IMG_H - 1)) ||
                      (out_col == '0) || (out_col == CW'(IMG_W - 1));
  assign last_now   = (out_row == RW'(IMG_H - 1)) && (out_col == CW'(IMG_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    latch   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        latch   = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        s_ready = adv;
        busy    = 1'b1;
        if (acc && last_pos) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (flush_end) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (m_valid && m_ready && m_last) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef EPF_BYPASS_EN
  logic byp_q;
  assign byp_on = byp_q;
`else
  assign byp_on = 1'b0;
`endif

  // Beats before IMG_W+1 only prime the window; every later beat yields one centre.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_col    <= '0;
      in_row    <= '0;
      out_col   <= '0;
      out_row   <= '0;
      pre_cnt   <= '0;
      flush_cnt <= '0;
      thr_q     <= '0;
`ifdef EPF_BYPASS_EN
      byp_q     <= 1'b0;
`endif
    end else begin
      if (latch) begin
        thr_q   <= thresh;
`ifdef EPF_BYPASS_EN
        byp_q   <= bypass;
`endif
        in_col  <= '0;
        in_row  <= '0;
        out_col <= '0;
        out_row <= '0;
        pre_cnt <= PW'(IMG_W + 1);
      end else if (beat) begin
        if (in_col == CW'(IMG_W - 1)) begin
          in_col <= '0;
          in_row <= (in_row == RW'(IMG_H - 1)) ? '0 : in_row + RW'(1);
        end else begin
          in_col <= in_col + CW'(1);
        end
        if (!pre_done) begin
          pre_cnt <= pre_cnt - PW'(1);
        end else if (out_col == CW'(IMG_W - 1)) begin
          out_col <= '0;
          out_row <= (out_row == RW'(IMG_H - 1)) ? '0 : out_row + RW'(1);
        end else begin
          out_col <= out_col + CW'(1);
        end
      end
      if (acc && last_pos)
        flush_cnt <= PW'(IMG_W);
      else if (state_q == S_FLUSH && adv && flush_cnt != '0)
        flush_cnt <= flush_cnt - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      lb0[in_col] <= beat_pix;
      lb1[in_col] <= lb0_rd;
    end
  end

  logic [SW-1:0]     sum, q0, quo;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] nb, diff, filt;
  logic [QW-1:0]     rec;
  logic [MW-1:0]     prod;
  logic [SW+3:0]     back;

  function automatic logic [QW-1:0] recip(input logic [3:0] k);
    case (k)
      4'd2:    recip = QW'((ONE_SH + 1) / 2);
      4'd3:    recip = QW'((ONE_SH + 2) / 3);
      4'd4:    recip = QW'((ONE_SH + 3) / 4);
      4'd5:    recip = QW'((ONE_SH + 4) / 5);
      4'd6:    recip = QW'((ONE_SH + 5) / 6);
      4'd7:    recip = QW'((ONE_SH + 6) / 7);
      4'd8:    recip = QW'((ONE_SH + 7) / 8);
      4'd9:    recip = QW'((ONE_SH + 8) / 9);
      default: recip = QW'(ONE_SH);
    endcase
  endfunction

  always_comb begin
    sum  = SW'(win[4]);
    cnt  = 4'd1;
    nb   = '0;
    diff = '0;
    for (int i = 0; i < 9; i++) begin
      if (i != 4) begin
        nb   = win[i];
        diff = (nb >= win[4]) ? nb - win[4] : win[4] - nb;
        if (diff <= thr_q) begin
          sum = sum + SW'(nb);
          cnt = cnt + 4'd1;
        end
      end
    end
  end

  // Ceiling reciprocal with SH fraction bits is exact for sums below 2^(DATA_W+4); the
  // back-multiply guards the one-high case anyway.
  always_comb begin
    rec  = recip(cnt);
    prod = MW'(sum) * MW'(rec);
    q0   = SW'(prod >> SH);
    back = (SW+4)'(q0) * (SW+4)'(cnt);
    quo  = (back > (SW+4)'(sum)) ? q0 - SW'(1) : q0;
    filt = DATA_W'(quo);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
      w_valid  <= 1'b0;
      w_border <= 1'b0;
      w_last   <= 1'b0;
      m_valid  <= 1'b0;
      m_pixel  <= '0;
      m_last   <= 1'b0;
    end else begin
      if (beat) begin
        win[0]   <= win[1];
        win[1]   <= win[2];
        win[2]   <= lb1_rd;
        win[3]   <= win[4];
        win[4]   <= win[5];
        win[5]   <= lb0_rd;
        win[6]   <= win[7];
        win[7]   <= win[8];
        win[8]   <= beat_pix;
        w_border <= border_now;
        w_last   <= last_now;
      end
      if (adv) begin
        w_valid <= beat && pre_done;
        m_valid <= w_valid;
        m_last  <= w_valid && w_last;
        if (w_valid) m_pixel <= (w_border || byp_on) ? win[4] : filt;
      end
    end
  end

endmodule

// File: tb/tb_epf_stream_3x3.sv
// Bench for epf_stream_3x3 (8x8 frames): directed vector table plus randomized frames with
// backpressure and source gaps, checked against a plain-arithmetic reference filter.
module tb_epf_stream_3x3;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int N  = W * H;

  logic          clk, rst, start;
  logic [DW-1:0] thresh;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_pixel;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_pixel;
  logic          m_last, busy, done;
`ifdef EPF_BYPASS_EN
  logic          bypass;
`endif

  epf_stream_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .thresh(thresh),
`ifdef EPF_BYPASS_EN
    .bypass(bypass),
`endif
    .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .m_valid(m_valid), .m_ready(m_ready), .m_pixel(m_pixel),
    .m_last(m_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int thr;
    int row;
    int col;
    int exp;
  } vec_t;

  vec_t vt[10];
  int   img[N];
  int   exp_o[N];
  int   got[N];
  int   got_ref[N];
  int   ngot;
  int   checks;
  int   errors;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void build(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0:       img[r*W+c] = 100;
          1:       img[r*W+c] = (r == 4 && c == 4) ? 200 : 100;
          2:       img[r*W+c] = (c < 4) ? 50 : 150;
          default: img[r*W+c] = int'($urandom_range(0, 255));
        endcase
  endfunction

  // Mean of the centre and every neighbour within thresh; borders and bypass pass through.
  function automatic void model(input int thr, input bit byp);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        int ctr, s, k;
        ctr = img[r*W+c];
        if (byp || r == 0 || r == H-1 || c == 0 || c == W-1) begin
          exp_o[r*W+c] = ctr;
        end else begin
          s = 0;
          k = 0;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
              int n, d;
              n = img[(r+dr)*W + (c+dc)];
              d = (n > ctr) ? n - ctr : ctr - n;
              if (d <= thr) begin
                s += n;
                k++;
              end
            end
          exp_o[r*W+c] = s / k;
        end
      end
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_m_valid"}, int'(m_valid), 0);
    check({tag, "_m_pixel"}, int'(m_pixel), 0);
    check({tag, "_m_last"},  int'(m_last),  0);
    check({tag, "_s_ready"}, int'(s_ready), 0);
    check({tag, "_busy"},    int'(busy),    0);
    check({tag, "_done"},    int'(done),    0);
  endtask

  task automatic do_reset(input string tag);
    rst     = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    check_idle_outputs({tag, "_async"});
    @(negedge clk);
    check_idle_outputs({tag, "_hold"});
    rst = 1'b0;
    @(negedge clk);
    #1;
  endtask

  // Runs one frame from IDLE; abort_at >= 0 pulses reset after that many accepted pixels.
  task automatic run_frame(input int thr, input int rdy_pct, input int vld_pct, input int abort_at);
    int sent, phase, prev_pix, prev_last;
    bit prev_stall, fin;
    sent       = 0;
    ngot       = 0;
    phase      = 0;
    prev_stall = 1'b0;
    prev_pix   = 0;
    prev_last  = 0;
    fin        = 1'b0;
    for (int i = 0; i < N; i++) got[i] = -1;
    start  = 1'b1;
    thresh = DW'(thr);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_after_start", int'(busy), 1);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      start   = (phase == 0) && ($urandom_range(0, 7) == 0);
      m_ready = int'($urandom_range(0, 99)) < rdy_pct;
      s_valid = (phase == 0) && (sent >= N || int'($urandom_range(0, 99)) < vld_pct);
      s_pixel = (sent < N) ? DW'(img[sent]) : DW'($urandom_range(0, 255));
      #1;
      if (phase == 1) begin
        check("done_pulse", int'(done), 1);
        check("busy_in_done", int'(busy), 0);
        phase = 2;
      end else if (phase == 2) begin
        check("done_cleared", int'(done), 0);
        check("busy_idle", int'(busy), 0);
        check("m_valid_idle", int'(m_valid), 0);
        fin = 1'b1;
      end else begin
        check("no_early_done", int'(done), 0);
        if (prev_stall) begin
          check("hold_valid", int'(m_valid), 1);
          check("hold_pixel", int'(m_pixel), prev_pix);
          check("hold_last", int'(m_last), prev_last);
        end
        if (m_valid && !m_ready) check("stall_s_ready", int'(s_ready), 0);
        if (s_valid && s_ready) begin
          if (sent < N) sent++;
          else check("extra_accept", int'(s_ready), 0);
        end
        if (m_valid && m_ready) begin
          if (ngot < N) begin
            got[ngot] = int'(m_pixel);
            check("m_last_pos", int'(m_last), (ngot == N-1) ? 1 : 0);
            ngot++;
            if (ngot == N) phase = 1;
          end else begin
            check("extra_output", int'(m_valid), 0);
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_pix   = int'(m_pixel);
        prev_last  = int'(m_last);
        if (abort_at >= 0 && sent >= abort_at) begin
          do_reset("abort_rst");
          return;
        end
      end
      if (!fin) @(negedge clk);
    end
    if (!fin) begin
      check("frame_timeout_phase", phase, 2);
      do_reset("timeout_rst");
    end
  endtask

  task automatic compare_frame(input string name);
    int mism;
    mism = 0;
    for (int i = 0; i < N; i++)
      if (got[i] != exp_o[i]) mism++;
    check({name, "_mismatches"}, mism, 0);
    check({name, "_count"}, ngot, N);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int thr, mism;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    thresh  = '0;
    s_valid = 1'b0;
    s_pixel = '0;
    m_ready = 1'b0;
`ifdef EPF_BYPASS_EN
    bypass  = 1'b0;
`endif
    vt[0] = '{0,  16, 4, 4, 100};
    vt[1] = '{0,  16, 0, 0, 100};
    vt[2] = '{1,  16, 4, 4, 200};
    vt[3] = '{1,  16, 3, 4, 100};
    vt[4] = '{1, 255, 4, 4, 111};
    vt[5] = '{1, 255, 3, 3, 111};
    vt[6] = '{2,  20, 2, 3,  50};
    vt[7] = '{2,  20, 2, 4, 150};
    vt[8] = '{2, 100, 2, 3,  83};
    vt[9] = '{2, 100, 2, 4, 116};

    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_idle_outputs("post_reset");

    for (int i = 0; i < 10; i++) begin
      build(vt[i].kind);
      model(vt[i].thr, 1'b0);
      run_frame(vt[i].thr, 100, 100, -1);
      check($sformatf("vec%0d_pixel_r%0d_c%0d", i, vt[i].row, vt[i].col),
            got[vt[i].row*W + vt[i].col], vt[i].exp);
      compare_frame($sformatf("vec%0d_frame", i));
    end

    for (int f = 0; f < 3; f++) begin
      build(3);
      thr = int'($urandom_range(0, 80));
      model(thr, 1'b0);
      run_frame(thr, 100, 100, -1);
      compare_frame($sformatf("rand%0d_fast", f));
      for (int i = 0; i < N; i++) got_ref[i] = got[i];
      run_frame(thr, 50, 60, -1);
      compare_frame($sformatf("rand%0d_stall", f));
      mism = 0;
      for (int i = 0; i < N; i++)
        if (got[i] != got_ref[i]) mism++;
      check($sformatf("rand%0d_stall_vs_fast", f), mism, 0);
    end

    build(3);
    thr = int'($urandom_range(0, 80));
    run_frame(thr, 70, 80, 30);
    build(3);
    thr = int'($urandom_range(0, 80));
    model(thr, 1'b0);
    run_frame(thr, 60, 70, -1);
    compare_frame("after_abort");

`ifdef EPF_BYPASS_EN
    build(3);
    thr = 255;
    model(thr, 1'b1);
    bypass = 1'b1;
    run_frame(thr, 50, 70, -1);
    compare_frame("bypass");
    bypass = 1'b0;
    model(thr, 1'b0);
    run_frame(thr, 50, 70, -1);
    compare_frame("bypass_off");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
